// File: rtl/dmem_ctrl.sv
// Data-memory controller between the core's data port and a single-port
// synchronous SRAM. One access at a time: IDLE issues the SRAM strobe,
// RD_WAIT/WR_WAIT count out the SRAM latency, and DONE releases the core
// for exactly one cycle.
//
// Core handshake: a request (p_MemRead or any p_MemWrite bit) is "valid"
// while held high. It is accepted in IDLE in the same cycle it appears,
// and p_MemWait is high from that cycle until the access completes. The
// DONE cycle, where p_MemWait is low, is the "ready": the core advances
// on the edge that ends DONE. A request seen during DONE is ignored and
// is serviced from IDLE on the following cycle.
module dmem_ctrl #(
    parameter int WIDTH     = 64,
    parameter int ADDR_BITS = 12,
    parameter int RD_LAT    = 2,
    parameter int WR_LAT    = 1
) (
    input  logic                 p_clk,
    input  logic                 p_rst_l,
    input  logic [WIDTH-1:0]     p_MemAddress,
    input  logic                 p_MemRead,
    input  logic [3:0]           p_MemWrite,
    input  logic [WIDTH-1:0]     p_MemDataOut,
    output logic [WIDTH-1:0]     p_MemDataIn,
    output logic                 p_MemWait,
    output logic                 sram_en,
    output logic [3:0]           sram_we,
    output logic [ADDR_BITS-1:0] sram_addr,
    output logic [WIDTH-1:0]     sram_wdata,
    input  logic [WIDTH-1:0]     sram_rdata,
    output logic                 p_err_addr,
    output logic                 p_err_rw,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Counter preloads: the issue cycle itself is one cycle of latency.
    localparam logic [2:0] RD_CNT = 3'(RD_LAT - 1);
    localparam logic [2:0] WR_CNT = 3'(WR_LAT - 1);

    state_t     state;
    logic [2:0] cnt;

    logic req;
    logic is_wr;
    logic addr_hi;
    logic issue;

    assign req     = p_MemRead | (|p_MemWrite);
    // Any write lane wins over a simultaneous read.
    assign is_wr   = |p_MemWrite;
    // Byte address bits above the SRAM word index must be zero.
    assign addr_hi = (p_MemAddress >> (ADDR_BITS + 3)) != '0;
    // Gated by reset so nothing reaches the SRAM while reset is held.
    assign issue   = p_rst_l && (state == IDLE) && req;

    assign dbg_state = state;

    // Stall the core from the accepting cycle through the last wait cycle.
    assign p_MemWait = p_rst_l && (issue || (state == RD_WAIT) || (state == WR_WAIT));

    // SRAM command: driven straight from the core inputs in the issue cycle, quiet otherwise.
    always_comb begin
        sram_en    = issue;
        sram_we    = 4'h0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (issue) begin
            sram_we    = p_MemWrite;
            sram_addr  = p_MemAddress[ADDR_BITS+2:3];
            sram_wdata = p_MemDataOut;
        end
    end

    // Access sequencing, load-data capture and sticky error flags.
    always_ff @(posedge p_clk) begin
        if (!p_rst_l) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            p_MemDataIn <= '0;
            p_err_addr  <= 1'b0;
            p_err_rw    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (is_wr) begin
                            state <= WR_WAIT;
                            cnt   <= WR_CNT;
                        end else begin
                            state <= RD_WAIT;
                            cnt   <= RD_CNT;
                        end
                        if (p_MemRead && is_wr) p_err_rw <= 1'b1;
                        if (addr_hi) p_err_addr <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (cnt == 3'd0) begin
                        p_MemDataIn <= sram_rdata;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                WR_WAIT: begin
                    if (cnt == 3'd0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: a behavioural SRAM on the memory side, a word-array
// reference memory plus per-access timing rules on the core side, and one
// negedge compare process that checks every output every cycle.
module tb_dmem_ctrl;

    localparam int WIDTH     = 64;
    localparam int ADDR_BITS = 12;
    localparam int RD_LAT    = 2;
    localparam int WR_LAT    = 1;
    localparam int DEPTH     = 1 << ADDR_BITS;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 p_rst_l = 1'b0;
    logic [WIDTH-1:0]     p_MemAddress = '0;
    logic                 p_MemRead = 1'b0;
    logic [3:0]           p_MemWrite = 4'h0;
    logic [WIDTH-1:0]     p_MemDataOut = '0;
    logic [WIDTH-1:0]     p_MemDataIn;
    logic                 p_MemWait;
    logic                 sram_en;
    logic [3:0]           sram_we;
    logic [ADDR_BITS-1:0] sram_addr;
    logic [WIDTH-1:0]     sram_wdata;
    logic [WIDTH-1:0]     sram_rdata;
    logic                 p_err_addr;
    logic                 p_err_rw;
    logic [1:0]           dbg_state;

    dmem_ctrl #(
        .WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
    ) dut (
        .p_clk(clk),
        .p_rst_l(p_rst_l),
        .p_MemAddress(p_MemAddress),
        .p_MemRead(p_MemRead),
        .p_MemWrite(p_MemWrite),
        .p_MemDataOut(p_MemDataOut),
        .p_MemDataIn(p_MemDataIn),
        .p_MemWait(p_MemWait),
        .sram_en(sram_en),
        .sram_we(sram_we),
        .sram_addr(sram_addr),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata),
        .p_err_addr(p_err_addr),
        .p_err_rw(p_err_rw),
        .dbg_state(dbg_state)
    );

    // 16-bit lane merge: lane i covers bits [16i+15:16i].
    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                          input logic [3:0] we);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (we[i]) r[16*i +: 16] = nw[16*i +: 16];
        end
        return r;
    endfunction

    // ---------------- behavioural SRAM (environment) ----------------
    logic [63:0] sram_mem [0:DEPTH-1];
    logic [63:0] rd_pipe [0:RD_LAT-1];

    always @(posedge clk) begin
        if (sram_en && sram_we != 4'h0) sram_mem[sram_addr] <= merge(sram_mem[sram_addr], sram_wdata, sram_we);
        rd_pipe[0] <= sram_en ? sram_mem[sram_addr] : 64'hDEAD_BEEF_DEAD_BEEF;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign sram_rdata = rd_pipe[RD_LAT-1];

    // ---------------- reference model / scoreboard ----------------
    logic [63:0] ref_mem [0:DEPTH-1];
    logic [63:0] exp_q[$];

    logic        chk_on = 1'b0;
    logic        exp_en = 1'b0;
    logic        exp_wait = 1'b0;
    logic [3:0]  exp_we = 4'h0;
    logic [11:0] exp_addr = '0;
    logic [63:0] exp_wdata = '0;
    logic [63:0] exp_din = '0;
    logic        exp_err_rw = 1'b0;
    logic        exp_err_addr = 1'b0;
    logic        pend_rw = 1'b0;
    logic        pend_addr = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process: every output, every cycle, away from the rising edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("sram_en", 64'(sram_en), 64'(exp_en));
            chk("p_MemWait", 64'(p_MemWait), 64'(exp_wait));
            chk("p_MemDataIn", p_MemDataIn, exp_din);
            chk("p_err_rw", 64'(p_err_rw), 64'(exp_err_rw));
            chk("p_err_addr", 64'(p_err_addr), 64'(exp_err_addr));
            if (exp_en) begin
                chk("sram_we", 64'(sram_we), 64'(exp_we));
                chk("sram_addr", 64'(sram_addr), 64'(exp_addr));
                chk("sram_wdata", sram_wdata, exp_wdata);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Advance one cycle; error flags set by an accepted access show up one cycle later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        exp_err_rw   = exp_err_rw | pend_rw;
        exp_err_addr = exp_err_addr | pend_addr;
        pend_rw      = 1'b0;
        pend_addr    = 1'b0;
    endtask

    task automatic drive_idle(input int n);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            p_MemRead = 1'b0;
            p_MemWrite = 4'h0;
            p_MemAddress = {$urandom, $urandom};
            p_MemDataOut = {$urandom, $urandom};
            exp_en = 1'b0;
            exp_wait = 1'b0;
        end
    endtask

    // Hold reset n cycles (n >= 2), optionally with a read request held, then release.
    task automatic reset_seq(input int n, input logic hold_rd);
        next_cycle();
        chk_on = 1'b1;
        p_rst_l = 1'b0;
        p_MemRead = hold_rd;
        p_MemWrite = 4'h0;
        exp_en = 1'b0;
        exp_wait = 1'b0;
        for (int c = 1; c < n; c++) begin
            next_cycle();
            exp_din = '0;
            exp_err_rw = 1'b0;
            exp_err_addr = 1'b0;
            exp_q.delete();
        end
        next_cycle();
        p_rst_l = 1'b1;
        p_MemRead = 1'b0;
        p_MemWrite = 4'h0;
        exp_din = '0;
        exp_err_rw = 1'b0;
        exp_err_addr = 1'b0;
    endtask

    // One access. Request inputs held for cycles 0..hold-1 of the access, then dropped.
    task automatic access(input logic rd, input logic [3:0] we, input logic [63:0] addr,
                          input logic [63:0] wd, input int hold,
                          input logic lit_en, input logic [63:0] lit);
        logic wr;
        int lat;
        logic [11:0] idx;
        wr  = (we != 4'h0);
        lat = wr ? WR_LAT : RD_LAT;
        idx = addr[14:3];
        next_cycle();
        p_MemRead = rd;
        p_MemWrite = we;
        p_MemAddress = addr;
        p_MemDataOut = wd;
        exp_en = 1'b1;
        exp_wait = 1'b1;
        exp_we = we;
        exp_addr = idx;
        exp_wdata = wd;
        if (wr) ref_mem[idx] = merge(ref_mem[idx], wd, we);
        else exp_q.push_back(ref_mem[idx]);
        pend_rw = rd & wr;
        pend_addr = (addr[63:15] != '0);
        for (int c = 1; c <= lat + 1; c++) begin
            next_cycle();
            exp_en = 1'b0;
            if (c >= hold) begin
                p_MemRead = 1'b0;
                p_MemWrite = 4'h0;
                p_MemAddress = {$urandom, $urandom};
                p_MemDataOut = {$urandom, $urandom};
            end
            if (c == lat + 1) begin
                exp_wait = 1'b0;
                if (!wr) exp_din = exp_q.pop_front();
                if (lit_en) begin
                    chk("model_data", exp_din, lit);
                    chk("done_data", p_MemDataIn, lit);
                end
            end
        end
    endtask

    // Start a read, then assert reset while it is still waiting on the SRAM.
    task automatic read_abort(input logic [63:0] addr);
        next_cycle();
        p_MemRead = 1'b1;
        p_MemWrite = 4'h0;
        p_MemAddress = addr;
        p_MemDataOut = '0;
        exp_en = 1'b1;
        exp_wait = 1'b1;
        exp_we = 4'h0;
        exp_addr = addr[14:3];
        exp_wdata = '0;
        pend_addr = (addr[63:15] != '0);
        reset_seq(2, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            sram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        p_MemRead = 1'b1;

        // Reset held 3 cycles with a read pending.
        reset_seq(3, 1'b1);
        drive_idle(1);

        // Full write then read back.
        access(1'b0, 4'hF, 64'h40, 64'h1122334455667788, 9, 1'b0, '0);
        access(1'b1, 4'h0, 64'h40, 64'h0, 9, 1'b1, 64'h1122334455667788);
        drive_idle(1);

        // Single-lane write merges into lane 1 only.
        access(1'b0, 4'b0010, 64'h40, 64'hAAAAAAAAAAAAAAAA, 9, 1'b0, '0);
        access(1'b1, 4'h0, 64'h40, 64'h0, 9, 1'b1, 64'h11223344AAAA7788);

        // Read and write together: write wins, sticky rw error.
        access(1'b1, 4'hF, 64'h08, 64'hCAFEF00D12345678, 9, 1'b0, '0);
        drive_idle(2);
        access(1'b1, 4'h0, 64'h08, 64'h0, 9, 1'b1, 64'hCAFEF00D12345678);

        // High address bits: wraps to index 1, sticky addr error.
        access(1'b1, 4'h0, 64'h0001_0008, 64'h0, 9, 1'b1, 64'hCAFEF00D12345678);
        drive_idle(1);

        // Reset in the middle of a read, then a normal read.
        read_abort(64'h40);
        drive_idle(1);
        access(1'b1, 4'h0, 64'h40, 64'h0, 9, 1'b1, 64'h11223344AAAA7788);

        // Randomized traffic over a small index range to get read-after-write hits.
        for (int t = 0; t < 300; t++) begin
            int kind;
            logic rd;
            logic [3:0] we;
            logic [63:0] addr;
            kind = $urandom_range(0, 9);
            rd = (kind <= 3) || (kind == 9);
            we = (kind >= 4) ? 4'($urandom_range(1, 15)) : 4'h0;
            addr = (64'($urandom_range(0, 15)) << 3) | 64'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) addr = addr | (64'($urandom_range(1, 255)) << 20);
            access(rd, we, addr, {$urandom, $urandom}, $urandom_range(1, 4), 1'b0, '0);
            drive_idle($urandom_range(0, 2));
        end

        drive_idle(3);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
